// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding for the sequential SubBytes engine
// and the pipeline depth of the registered S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SBOX_LAT = 1;

endpackage

// File: rtl/sbox.sv
// AES forward S-box with a registered output (one cycle of latency, no reset).
// Storage is a constant lookup table indexed by the input byte.
module sbox (
  input  logic [7:0] si,
  input  logic       clk,
  output logic [7:0] so
);

  localparam logic [7:0] SBOX_ROM [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_ff @(posedge clk) begin
    so <= SBOX_ROM[si];
  end

endmodule

// File: rtl/subbytes_seq.sv
// Sequential AES SubBytes/SubWord: one shared registered S-box, one byte per cycle,
// result valid NUM_BYTES+1 edges after accept and held until out_ready.
module subbytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BYTES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       widx;
  logic [W-1:0]        blk;
  logic [SBOX_LAT-1:0] feed_d;
  logic                feed_now;
  logic                wr_en;
  logic                cnt_last;
  logic                accept;
  logic [7:0]          sbox_si;
  logic [7:0]          sbox_so;

  assign feed_now = (state == FEED);
  assign cnt_last = (cnt == CNT_LAST);
  assign accept   = in_valid & in_ready;
  assign out_data = blk;
  // S-box output is only committed one lookup after a FEED cycle; this gate keeps
  // its unreset register away from the block after reset.
  assign wr_en    = feed_d[SBOX_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    sbox_si   = 8'h00;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_nxt = FEED;
      end
      FEED: begin
        busy    = 1'b1;
        sbox_si = blk[{cnt, 3'b000} +: 8];
        if (cnt_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      widx   <= '0;
      blk    <= '0;
      feed_d <= '0;
    end else begin
      feed_d <= SBOX_LAT'({feed_d, feed_now});
      widx   <= cnt;
      if (accept) begin
        blk <= in_data;
        cnt <= '0;
      end else begin
        if (feed_now && !cnt_last) cnt <= cnt + CW'(1);
        if (wr_en) blk[{widx, 3'b000} +: 8] <= sbox_so;
      end
    end
  end

  sbox u_sbox (
    .si  (sbox_si),
    .clk (clk),
    .so  (sbox_so)
  );

endmodule

// File: tb/tb_subbytes_seq.sv
// Bench for subbytes_seq: directed vectors, backpressure, mid-block reset, SubWord
// variant and a randomized scoreboard run against an arithmetic GF(2^8) S-box model.
module tb_subbytes_seq;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [31:0]  in_data4, out_data4;

  int           errors;
  int           checks;
  logic [7:0]   sref [256];
  logic [127:0] exp_q [$];

  localparam logic [127:0] FIPS_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] FIPS_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;

  subbytes_seq #(.NUM_BYTES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  subbytes_seq #(.NUM_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S(v) = affine(v^-1) over GF(2^8), with 0 mapping to inverse 0.
  task automatic build_sref();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sref[v] = s;
    end
  endtask

  function automatic logic [127:0] ref16(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sref[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] ref4(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sref[d[8*k +: 8]];
    return r;
  endfunction

  // Offers one block, measures edges from accept to out_valid and busy cycles, then consumes it.
  task automatic run_block(input logic [127:0] d, output logic [127:0] res, output int lat, output int bc);
    int guard;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    bc  = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      lat++;
      @(negedge clk);
    end
    res = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_block4(input logic [31:0] d, output logic [31:0] res, output int lat);
    int guard;
    @(negedge clk);
    in_data4  = d;
    in_valid4 = 1'b1;
    guard = 0;
    while (!in_ready4 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin lat++; @(negedge clk); end
    res = out_data4;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset16: in_ready=%b out_valid=%b busy=%b out_data=%h, required 0 0 0 0",
               in_ready, out_valid, busy, out_data);
    end
    checks++;
    if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || out_data4 !== 32'h0) begin
      errors++;
      $display("FAIL reset4: in_ready=%b out_valid=%b busy=%b out_data=%h, required 0 0 0 0",
               in_ready4, out_valid4, busy4, out_data4);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b in_ready4=%b, required 1 1", in_ready, in_ready4);
    end
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int lat, bc;
    run_block(FIPS_IN, res, lat, bc);
    checks++;
    if (res !== FIPS_OUT) begin
      errors++;
      $display("FAIL fips_data: got %h, required %h", res, FIPS_OUT);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL fips_latency: got %0d edges, required 17", lat);
    end
  endtask

  task automatic test_zero_ff();
    logic [127:0] res;
    int lat, bc;
    run_block(128'h0, res, lat, bc);
    checks++;
    if (res !== {16{8'h63}}) begin
      errors++;
      $display("FAIL zero_data: got %h, required %h", res, {16{8'h63}});
    end
    checks++;
    if (bc !== 17) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required 17", bc);
    end
    run_block({128{1'b1}}, res, lat, bc);
    checks++;
    if (res !== {16{8'h16}}) begin
      errors++;
      $display("FAIL ones_data: got %h, required %h", res, {16{8'h16}});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, e1, e2;
    int guard, lat;
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    e1 = ref16(d1);
    e2 = ref16(d2);
    @(negedge clk);
    in_data  = d1;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_data = d2;
    guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== e1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b data=%h, required 1 0 %h",
                 i, out_valid, in_ready, out_data, e1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_next: busy=%b, required 1", busy);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 3) in_valid = 1'b0;
      lat++;
      @(negedge clk);
    end
    checks++;
    if (out_data !== e2 || lat !== 17) begin
      errors++;
      $display("FAIL bp_second: data=%h latency=%0d, required %h 17", out_data, lat, e2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_double: busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_midfeed();
    logic [127:0] res;
    int guard, lat, bc, seen;
    @(negedge clk);
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL midfeed_reset: out_valid=%b busy=%b data=%h, required 0 0 0", out_valid, busy, out_data);
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midfeed_abandon: out_valid seen %0d cycles, required 0", seen);
    end
    run_block(FIPS_IN, res, lat, bc);
    checks++;
    if (res !== FIPS_OUT || lat !== 17) begin
      errors++;
      $display("FAIL midfeed_recover: data=%h latency=%0d, required %h 17", res, lat, FIPS_OUT);
    end
  endtask

  task automatic test_subword();
    logic [31:0] res, d;
    int lat;
    run_block4(32'hcf4f3c09, res, lat);
    checks++;
    if (res !== 32'h8a84eb01) begin
      errors++;
      $display("FAIL subword_data: got %h, required 8a84eb01", res);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL subword_latency: got %0d edges, required 5", lat);
    end
    for (int i = 0; i < 20; i++) begin
      d = $urandom();
      run_block4(d, res, lat);
      checks++;
      if (res !== ref4(d) || lat !== 5) begin
        errors++;
        $display("FAIL subword_rand[%0d]: in=%h got %h latency=%0d, required %h 5", i, d, res, lat, ref4(d));
      end
    end
  endtask

  task automatic test_random();
    int sent, rcv, cyc;
    logic [127:0] d, e;
    sent = 0;
    rcv  = 0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int guard;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d = {$urandom(), $urandom(), $urandom(), $urandom()};
          in_data  = d;
          in_valid = 1'b1;
          guard = 0;
          while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
          if (in_ready) begin
            exp_q.push_back(ref16(d));
            sent++;
          end
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin
        cyc = 0;
        while (rcv < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_extra: unexpected block %h", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) begin
                errors++;
                $display("FAIL rand_block[%0d]: got %h, required %h", rcv, out_data, e);
              end
            end
            rcv++;
          end
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (sent !== 1000 || rcv !== 1000 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count: sent=%0d received=%0d pending=%0d, required 1000 1000 0",
               sent, rcv, exp_q.size());
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    in_data4   = '0;
    out_ready4 = 1'b0;
    build_sref();
    test_reset();
    test_fips();
    test_zero_ff();
    test_backpressure();
    test_reset_midfeed();
    test_subword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subbytes_seq.md
SUBBYTES_SEQ -- requirements
Module: subbytes_seq

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16, bytes per block; legal values 4 (SubWord) and 16 (SubBytes); data width W = 8*NUM_BYTES.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  input block offered.
REQ-005 SHALL have port in_ready  output  1  block accepted on the edge where in_valid & in_ready.
REQ-006 SHALL have port in_data  input  W  input block; byte k = bits [8k+7:8k].
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  result consumed on the edge where out_valid & out_ready.
REQ-009 SHALL have port out_data  output  W  result block; byte k = S(in byte k).
REQ-010 SHALL have port busy  output  1  high in FEED and DRAIN.

Function
REQ-011 SHALL process one block at a time through one shared, registered, 1-cycle-latency S-box, at one byte per cycle.
REQ-012 SHALL implement FSM IDLE -> FEED -> DRAIN -> DONE -> IDLE.
REQ-013 IDLE: in_ready = 1 unless rst is high. On accept, SHALL load in_data into the block register, clear byte counter cnt, and go to FEED.
REQ-014 FEED: SHALL drive S-box input with block byte cnt, then increment cnt. When cnt = NUM_BYTES-1, SHALL go to DRAIN.
REQ-015 Each edge after the first FEED cycle SHALL write the S-box output into block byte cnt-1, overwriting in place. The write index SHALL be a 1-cycle-delayed copy of cnt.
REQ-016 DRAIN: SHALL write the last byte (NUM_BYTES-1), then go to DONE.
REQ-017 DONE: out_valid = 1 and out_data = block register. Both SHALL hold stable until out_ready. On out_ready, SHALL go to IDLE.
REQ-018 Latency SHALL be exactly NUM_BYTES+1 edges from the accept edge to out_valid rising. Minimum spacing between accepts SHALL be NUM_BYTES+3 cycles.
REQ-019 in_valid asserted outside IDLE SHALL be ignored, with no effect on state or data.
REQ-020 S-box input SHALL be 8'h00 in every state except FEED, to suppress data-dependent toggling.
REQ-021 The counter width SHALL be clog2(NUM_BYTES) bits, with no wrap beyond NUM_BYTES-1.
REQ-022 out_data SHALL be meaningful only while out_valid = 1. Outside DONE it SHALL keep the block register value.

Reset
REQ-023 On an edge with rst high: state = IDLE, cnt = 0, write index = 0, block register = 0.
REQ-024 Output reset values: out_valid = 0, busy = 0, out_data = 0. in_ready SHALL be 0 while rst is high and 1 on the first cycle after release.
REQ-025 Reset mid-FEED, mid-DRAIN or in DONE SHALL abandon the block with no partial out_valid. The S-box's own unreset register SHALL never reach out_data without a write-enable gate.

Structure
REQ-026 Shared package aes_pkg SHALL hold: FSM state encoding (IDLE, FEED, DRAIN, DONE) and constant SBOX_LAT = 1.
REQ-027 SHALL contain exactly one sub-module instance: sbox (8-bit SI, clk, 8-bit registered SO).
REQ-028 The FSM, counter, write-index register and block register SHALL be local to subbytes_seq. Total RTL SHALL be 120-400 lines.

Verification
REQ-029 FIPS-197 round-1 vector: in_data = 128'h00102030405060708090a0b0c0d0e0f0 -> out_data = 128'h63cab7040953d051cd60e0e7ba70e18c, with out_valid 17 edges after accept.
REQ-030 All-zero input -> all bytes 8'h63. All-0xFF input -> all bytes 8'h16. busy is high for exactly 17 cycles.
REQ-031 Backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_data stable, in_ready = 0. After release, next block accepted 1 cycle later; in_valid held high throughout is not double-accepted.
REQ-032 rst pulsed for 1 cycle on the 8th FEED cycle -> next cycle out_valid = 0, busy = 0. After release, a fresh FIPS vector yields the correct result with no corruption.
REQ-033 NUM_BYTES = 4: in_data = 32'hcf4f3c09 -> out_data = 32'h8a84eb01, with out_valid 5 edges after accept.
REQ-034 Random 1000 blocks with random valid/ready gaps, checked against a software S-box scoreboard; zero mismatches and no lost or duplicated blocks.
